// File: rtl/bot_batch_feeder.sv
// rtl/bot_batch_feeder.sv - batch command sequencer feeding bots to the counting pipeline
//
// Accepts a batch command (top + bot count), streams that many bots from the
// source toward the pipeline one cycle after each accepted beat, then waits
// for the pipeline's batch result and returns it with the latched top.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmdValid/cmdReady/cmdTop/cmdBotCount   batch command handshake
//   srcValid/srcReady/srcBot       bot source stream
//   top/isBotValid/bot/lastBotOfBatch/slowDownInput   drive side to pipeline
//   pipeResultsValid/pipeSum/pipeCount                results from pipeline
//   resValid/resTop/resSum/resCount                   completed batch result
//   errStatus                      sticky error flag (zero count, count
//                                  mismatch, unexpected pipeline result)
module bot_batch_feeder #(
    parameter int COUNT_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cmdValid,
    output logic                 cmdReady,
    input  logic [127:0]         cmdTop,
    input  logic [COUNT_W-1:0]   cmdBotCount,

    input  logic                 srcValid,
    output logic                 srcReady,
    input  logic [127:0]         srcBot,

    output logic [127:0]         top,
    output logic                 isBotValid,
    output logic [127:0]         bot,
    output logic                 lastBotOfBatch,
    input  logic                 slowDownInput,

    input  logic                 pipeResultsValid,
    input  logic [COUNT_W+34:0]  pipeSum,
    input  logic [COUNT_W-1:0]   pipeCount,

    output logic                 resValid,
    output logic [127:0]         resTop,
    output logic [COUNT_W+34:0]  resSum,
    output logic [COUNT_W-1:0]   resCount,

    output logic                 errStatus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    state_t               state;
    state_t               stateNext;
    logic [COUNT_W-1:0]   remaining;
    logic [COUNT_W-1:0]   batchCount;
    logic                 cmdFire;
    logic                 srcFire;
    logic                 lastFire;

    assign cmdFire  = cmdValid & cmdReady;
    assign srcFire  = srcValid & srcReady;
    assign lastFire = srcFire & (remaining == COUNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Handshake readies are gated by rst so nothing is consumed during reset.
    always_comb begin
        stateNext = state;
        cmdReady  = 1'b0;
        srcReady  = 1'b0;
        case (state)
            IDLE: begin
                cmdReady = ~rst;
                if (cmdFire && (cmdBotCount != '0)) begin
                    stateNext = STREAM;
                end
            end
            STREAM: begin
                srcReady = ~slowDownInput & ~rst;
                if (lastFire) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (pipeResultsValid) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top            <= '0;
            bot            <= '0;
            isBotValid     <= 1'b0;
            lastBotOfBatch <= 1'b0;
            remaining      <= '0;
            batchCount     <= '0;
            resValid       <= 1'b0;
            resTop         <= '0;
            resSum         <= '0;
            resCount       <= '0;
            errStatus      <= 1'b0;
        end else begin
            isBotValid     <= 1'b0;
            lastBotOfBatch <= 1'b0;
            resValid       <= 1'b0;

            if (cmdFire) begin
                if (cmdBotCount != '0) begin
                    top        <= cmdTop;
                    remaining  <= cmdBotCount;
                    batchCount <= cmdBotCount;
                end else begin
                    errStatus  <= 1'b1;
                end
            end

            // STREAM is left on the beat with remaining==1, so the
            // decrement below can never wrap.
            if (srcFire) begin
                bot            <= srcBot;
                isBotValid     <= 1'b1;
                remaining      <= remaining - COUNT_ONE;
                lastBotOfBatch <= lastFire;
            end

            if (pipeResultsValid) begin
                if (state == DRAIN) begin
                    resTop   <= top;
                    resSum   <= pipeSum;
                    resCount <= pipeCount;
                    resValid <= 1'b1;
                    if (pipeCount != batchCount) begin
                        errStatus <= 1'b1;
                    end
                end else begin
                    errStatus <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bot_batch_feeder.sv
// tb/tb_bot_batch_feeder.sv - self-checking bench for bot_batch_feeder
module tb_bot_batch_feeder;

    localparam int CW = 10;

    logic              clk;
    logic              rst;
    logic              cmdValid;
    logic              cmdReady;
    logic [127:0]      cmdTop;
    logic [CW-1:0]     cmdBotCount;
    logic              srcValid;
    logic              srcReady;
    logic [127:0]      srcBot;
    logic [127:0]      top;
    logic              isBotValid;
    logic [127:0]      bot;
    logic              lastBotOfBatch;
    logic              slowDownInput;
    logic              pipeResultsValid;
    logic [CW+34:0]    pipeSum;
    logic [CW-1:0]     pipeCount;
    logic              resValid;
    logic [127:0]      resTop;
    logic [CW+34:0]    resSum;
    logic [CW-1:0]     resCount;
    logic              errStatus;

    int errors;
    int checks;
    bit expErr;

    bot_batch_feeder #(.COUNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmdValid         (cmdValid),
        .cmdReady         (cmdReady),
        .cmdTop           (cmdTop),
        .cmdBotCount      (cmdBotCount),
        .srcValid         (srcValid),
        .srcReady         (srcReady),
        .srcBot           (srcBot),
        .top              (top),
        .isBotValid       (isBotValid),
        .bot              (bot),
        .lastBotOfBatch   (lastBotOfBatch),
        .slowDownInput    (slowDownInput),
        .pipeResultsValid (pipeResultsValid),
        .pipeSum          (pipeSum),
        .pipeCount        (pipeCount),
        .resValid         (resValid),
        .resTop           (resTop),
        .resSum           (resSum),
        .resCount         (resCount),
        .errStatus        (errStatus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [CW+34:0] rndSum();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return w[CW+34:0];
    endfunction

    task automatic doReset();
        rst = 1'b1;
        cmdValid = 1'b0; cmdTop = '0; cmdBotCount = '0;
        srcValid = 1'b0; srcBot = '0; slowDownInput = 1'b0;
        pipeResultsValid = 1'b0; pipeSum = '0; pipeCount = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expErr = 1'b0;
    endtask

    // Model: in STREAM a bot moves when srcValid && !slowDown; it appears on
    // the outputs one cycle later, flagged last when it was the count-th bot.
    // Entry and exit of this task are at a negedge with the DUT idle.
    task automatic runBatch(input int count, input logic [127:0] t,
                            input logic [31:0] slowMask, input logic [31:0] validMask,
                            input int drainDelay, input logic [CW-1:0] retCount,
                            input logic [CW+34:0] retSum);
        int rem;
        int cyc;
        bit prevXfer;
        bit prevLast;
        bit s;
        bit v;
        logic [127:0] prevBot;
        logic [CW-1:0] cntW;
        cntW = count[CW-1:0];

        srcValid = 1'b0; slowDownInput = 1'b0;
        cmdValid = 1'b1; cmdTop = t; cmdBotCount = cntW;
        #1;
        checks++;
        if (cmdReady !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_idle: got %b expected 1", cmdReady);
        end
        @(negedge clk);
        cmdValid = 1'b0; cmdTop = rnd128();

        rem = count; prevXfer = 0; prevLast = 0; prevBot = '0; cyc = 0;
        forever begin
            checks++;
            if (isBotValid !== prevXfer) begin
                errors++; $display("FAIL bot_valid: cyc %0d got %b expected %b", cyc, isBotValid, prevXfer);
            end
            if (prevXfer) begin
                checks++;
                if (bot !== prevBot) begin
                    errors++; $display("FAIL bot_data: cyc %0d got %h expected %h", cyc, bot, prevBot);
                end
            end
            checks++;
            if (lastBotOfBatch !== (prevXfer & prevLast)) begin
                errors++; $display("FAIL last_bot: cyc %0d got %b expected %b", cyc, lastBotOfBatch, prevXfer & prevLast);
            end
            checks++;
            if (top !== t) begin
                errors++; $display("FAIL top_stable: got %h expected %h", top, t);
            end
            checks++;
            if (resValid !== 1'b0) begin
                errors++; $display("FAIL res_valid_stream: got %b expected 0", resValid);
            end
            if (rem == 0) break;
            if (cyc >= 5000) begin
                checks++; errors++;
                $display("FAIL stream_timeout: %0d bots outstanding expected 0", rem);
                break;
            end
            v = (cyc < 32) ? validMask[cyc] : 1'b1;
            s = (cyc < 32) ? slowMask[cyc] : 1'b0;
            srcValid = v; slowDownInput = s; srcBot = rnd128();
            #1;
            checks++;
            if (srcReady !== !s) begin
                errors++; $display("FAIL src_ready_stream: cyc %0d got %b expected %b", cyc, srcReady, !s);
            end
            if (v && !s) begin
                prevXfer = 1; prevBot = srcBot; prevLast = (rem == 1); rem--;
            end else begin
                prevXfer = 0; prevLast = 0;
            end
            cyc++;
            @(negedge clk);
        end

        // DRAIN: source must be closed even with srcValid offered.
        srcValid = 1'b1; slowDownInput = 1'b0;
        #1;
        checks++;
        if (srcReady !== 1'b0) begin
            errors++; $display("FAIL src_ready_drain: got %b expected 0", srcReady);
        end
        for (int i = 0; i < drainDelay; i++) begin
            @(negedge clk);
            checks++;
            if (isBotValid !== 1'b0 || resValid !== 1'b0) begin
                errors++; $display("FAIL drain_quiet: got valid=%b res=%b expected 0 0", isBotValid, resValid);
            end
        end
        pipeResultsValid = 1'b1; pipeSum = retSum; pipeCount = retCount;
        @(negedge clk);
        pipeResultsValid = 1'b0; srcValid = 1'b0;
        if (retCount != cntW) expErr = 1'b1;
        checks++;
        if (resValid !== 1'b1) begin
            errors++; $display("FAIL res_valid: got %b expected 1", resValid);
        end
        checks++;
        if (resTop !== t) begin
            errors++; $display("FAIL res_top: got %h expected %h", resTop, t);
        end
        checks++;
        if (resSum !== retSum) begin
            errors++; $display("FAIL res_sum: got %h expected %h", resSum, retSum);
        end
        checks++;
        if (resCount !== retCount) begin
            errors++; $display("FAIL res_count: got %0d expected %0d", resCount, retCount);
        end
        checks++;
        if (errStatus !== expErr) begin
            errors++; $display("FAIL err_status: got %b expected %b", errStatus, expErr);
        end
    endtask

    task automatic test_reset();
        doReset();
        #1;
        checks++;
        if (cmdReady !== 1'b1 || srcReady !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got cmd=%b src=%b expected 1 0", cmdReady, srcReady);
        end
        checks++;
        if (isBotValid !== 1'b0 || lastBotOfBatch !== 1'b0 || resValid !== 1'b0 || errStatus !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got %b%b%b%b expected 0000", isBotValid, lastBotOfBatch, resValid, errStatus);
        end
        checks++;
        if (top !== '0 || bot !== '0 || resTop !== '0 || resSum !== '0 || resCount !== '0) begin
            errors++; $display("FAIL reset_data: got top=%h bot=%h resTop=%h resSum=%h resCount=%h expected all 0",
                               top, bot, resTop, resSum, resCount);
        end
    endtask

    task automatic test_basic();
        runBatch(3, rnd128(), 32'h0, 32'hffff_ffff, 2, CW'(3), (CW+35)'(7));
    endtask

    task automatic test_slowdown();
        runBatch(4, rnd128(), 32'b0110, 32'hffff_ffff, 0, CW'(4), rndSum());
    endtask

    task automatic test_back_to_back();
        runBatch(2, rnd128(), 32'h0, 32'hffff_ffff, 0, CW'(2), rndSum());
        runBatch(5, rnd128(), 32'b1010, 32'hffff_fff7, 1, CW'(5), rndSum());
    endtask

    task automatic test_max_count();
        runBatch((1 << CW) - 1, rnd128(), 32'h0, 32'hffff_ffff, 3, CW'((1 << CW) - 1), rndSum());
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int cnt;
            logic [CW-1:0] rc;
            cnt = $urandom_range(1, 20);
            rc = CW'(cnt);
            if ($urandom_range(0, 3) == 0) rc = rc + CW'(1);
            runBatch(cnt, rnd128(), $urandom(), $urandom() | 32'h1111_1111,
                     $urandom_range(0, 4), rc, rndSum());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_zero_count();
        logic [127:0] prevTop;
        prevTop = top;
        cmdValid = 1'b1; cmdTop = rnd128(); cmdBotCount = '0;
        @(negedge clk);
        cmdValid = 1'b0; srcValid = 1'b1;
        expErr = 1'b1;
        #1;
        checks++;
        if (errStatus !== 1'b1) begin
            errors++; $display("FAIL zero_err: got %b expected 1", errStatus);
        end
        checks++;
        if (cmdReady !== 1'b1 || srcReady !== 1'b0 || top !== prevTop) begin
            errors++; $display("FAIL zero_idle: got cmdReady=%b srcReady=%b top=%h expected 1 0 %h",
                               cmdReady, srcReady, top, prevTop);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (isBotValid !== 1'b0) begin
                errors++; $display("FAIL zero_no_bot: got %b expected 0", isBotValid);
            end
        end
        srcValid = 1'b0;
    endtask

    task automatic test_count_mismatch();
        #1;
        checks++;
        if (errStatus !== 1'b0) begin
            errors++; $display("FAIL mismatch_pre_err: got %b expected 0", errStatus);
        end
        runBatch(2, rnd128(), 32'h0, 32'hffff_ffff, 1, CW'(1), rndSum());
    endtask

    task automatic test_reset_mid();
        cmdValid = 1'b1; cmdTop = rnd128(); cmdBotCount = CW'(5);
        @(negedge clk);
        cmdValid = 1'b0; srcValid = 1'b1; slowDownInput = 1'b0; srcBot = rnd128();
        @(negedge clk);
        checks++;
        if (isBotValid !== 1'b1) begin
            errors++; $display("FAIL mid_first_bot: got %b expected 1", isBotValid);
        end
        // Reset lands with a command also presented; it must not be taken.
        rst = 1'b1; cmdValid = 1'b1; cmdTop = rnd128(); cmdBotCount = CW'(1);
        #1;
        checks++;
        if (srcReady !== 1'b0) begin
            errors++; $display("FAIL mid_src_ready_rst: got %b expected 0", srcReady);
        end
        @(negedge clk);
        rst = 1'b0; cmdValid = 1'b0;
        expErr = 1'b0;
        #1;
        checks++;
        if (srcReady !== 1'b0 || isBotValid !== 1'b0 || cmdReady !== 1'b1) begin
            errors++; $display("FAIL mid_after_rst: got src=%b valid=%b cmd=%b expected 0 0 1",
                               srcReady, isBotValid, cmdReady);
        end
        checks++;
        if (top !== '0) begin
            errors++; $display("FAIL mid_cmd_in_rst: got top=%h expected 0", top);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (resValid !== 1'b0 || isBotValid !== 1'b0 || srcReady !== 1'b0) begin
                errors++; $display("FAIL mid_abandoned: got res=%b valid=%b src=%b expected 0 0 0",
                                   resValid, isBotValid, srcReady);
            end
        end
        srcValid = 1'b0;
        @(negedge clk);
        runBatch(1, rnd128(), 32'h0, 32'hffff_ffff, 0, CW'(1), rndSum());
    endtask

    task automatic test_pipe_idle();
        @(negedge clk);
        pipeResultsValid = 1'b1; pipeSum = rndSum(); pipeCount = CW'(7);
        @(negedge clk);
        pipeResultsValid = 1'b0;
        expErr = 1'b1;
        #1;
        checks++;
        if (resValid !== 1'b0) begin
            errors++; $display("FAIL idle_pipe_res: got %b expected 0", resValid);
        end
        checks++;
        if (errStatus !== 1'b1 || cmdReady !== 1'b1) begin
            errors++; $display("FAIL idle_pipe_err: got err=%b cmdReady=%b expected 1 1", errStatus, cmdReady);
        end
        @(negedge clk);
        checks++;
        if (resValid !== 1'b0 || errStatus !== 1'b1) begin
            errors++; $display("FAIL idle_pipe_sticky: got res=%b err=%b expected 0 1", resValid, errStatus);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        expErr = 1'b0;
        test_reset();
        test_basic();
        test_slowdown();
        test_back_to_back();
        test_max_count();
        test_random();
        doReset();
        test_zero_count();
        doReset();
        test_count_mismatch();
        doReset();
        test_reset_mid();
        test_pipe_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
